alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter DWIDTH, default 128: operand/result width.
REQ-002 Parameter SETTLE_CYCLES, default 2: clock edges allowed for the combinational ALU to settle; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present; in_ready  output  1  request accepted this cycle when both high.
REQ-006 in_op1, in_op2  input  DWIDTH  operands; in_opsel  input  3  operation select; in_mode  input  1  arithmetic/logic mode.
REQ-007 alu_op1, alu_op2  output  DWIDTH; alu_opsel  output  3; alu_mode  output  1  registered operands driven to the ALU.
REQ-008 alu_result  input  DWIDTH; alu_c, alu_z, alu_o, alu_s  input  1 each  ALU outputs.
REQ-009 out_valid  output  1; out_ready  input  1  result handshake.
REQ-010 out_result  output  DWIDTH; out_flags  output  4  captured {c,z,o,s}.
REQ-011 busy  output  1  high in SETTLE or DONE.

Function
REQ-012 FSM states IDLE, SETTLE, DONE; 4-bit down-counter cnt.
REQ-013 in_ready = (state==IDLE) | (state==DONE & out_ready); it shall not depend on in_valid.
REQ-014 On accept (in_valid & in_ready): latch in_op1/in_op2/in_opsel/in_mode into alu_* registers, load cnt = SETTLE_CYCLES-1, go to SETTLE.
REQ-015 SETTLE: if cnt==0, capture alu_result into out_result and {alu_c,alu_z,alu_o,alu_s} into out_flags, set out_valid, go to DONE; else decrement cnt.
REQ-016 Latency: capture occurs on the SETTLE_CYCLES-th rising edge after the accept edge; out_valid is high from that edge on.
REQ-017 alu_* registers shall hold constant from accept until the next accept; in_valid during SETTLE is ignored.
REQ-018 DONE: out_valid=1, out_result and out_flags stable until out_valid & out_ready.
REQ-019 DONE with out_ready=1 and in_valid=0: clear out_valid, go to IDLE.
REQ-020 DONE with out_ready=1 and in_valid=1 (simultaneous): retire the result and accept the new request on the same edge; out_valid drops, state goes to SETTLE; no bubble cycle.
REQ-021 out_result and out_flags retain their last captured value after out_valid drops.
REQ-022 Back-to-back throughput: one result per SETTLE_CYCLES+1 cycles when out_ready is held high.

Reset
REQ-023 rst asserted shall immediately force state=IDLE, cnt=0, out_valid=0, all alu_*, out_result and out_flags to 0; busy=0; in_ready=1 after release.
REQ-024 Reset during SETTLE or DONE shall discard the in-flight operation; no out_valid pulse follows.

Structure
REQ-025 Shared package alu_pkg: DWIDTH default, opsel width, flag struct {c,z,o,s}, FSM state enum.
REQ-026 No sub-module; the ALU is instantiated beside this block at the parent level.

Verification
REQ-027 Single op, SETTLE_CYCLES=2: accept op1=5, op2=3 at edge E0; bench ALU drives result=8, flags 0000 -> out_valid rises at E2, out_result=8, out_flags=4'b0000.
REQ-028 Backpressure: out_ready=0 for 10 cycles while the bench changes alu_result -> out_result/out_flags unchanged, in_ready=0, alu_op1 stable.
REQ-029 Simultaneous retire+accept: in DONE with out_ready=1, in_valid=1 (op1=128'hFFFF...F, op2=1) -> out_valid drops at the next edge, alu_op1 updates, new result with alu_c=1, alu_z=1 -> out_flags=4'b1100.
REQ-030 Reset mid-SETTLE: assert rst one cycle after accept -> all outputs 0 asynchronously, no out_valid afterward, in_ready=1 after release.
REQ-031 SETTLE_CYCLES=1 and 15: latency measured exactly 1 and 15 edges; streaming with out_ready=1 yields one result every 2 and 16 cycles respectively.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencing controller and the ALU
// that sits beside it at the parent level.
package alu_pkg;

  localparam int DWIDTH_DEFAULT = 128;
  localparam int OPSEL_W        = 3;
  localparam int CNT_W          = 4;
  localparam int SETTLE_MAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic c;
    logic z;
    logic o;
    logic s;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } alu_state_t;

  // Counter preload so that capture lands on the settle_cycles-th edge after accept.
  function automatic logic [CNT_W-1:0] settle_preload(input int settle_cycles);
    return CNT_W'(settle_cycles - 1);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer for a multi-cycle combinational ALU: registers a request, waits a
// fixed number of edges for the ALU to settle, then holds the result until taken.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int DWIDTH        = DWIDTH_DEFAULT,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DWIDTH-1:0]  in_op1,
  input  logic [DWIDTH-1:0]  in_op2,
  input  logic [OPSEL_W-1:0] in_opsel,
  input  logic               in_mode,
  output logic [DWIDTH-1:0]  alu_op1,
  output logic [DWIDTH-1:0]  alu_op2,
  output logic [OPSEL_W-1:0] alu_opsel,
  output logic               alu_mode,
  input  logic [DWIDTH-1:0]  alu_result,
  input  logic               alu_c,
  input  logic               alu_z,
  input  logic               alu_o,
  input  logic               alu_s,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DWIDTH-1:0]  out_result,
  output logic [3:0]         out_flags,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = settle_preload(SETTLE_CYCLES);

  alu_state_t         r_state;
  alu_state_t         w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DWIDTH-1:0]  r_alu_op1;
  logic [DWIDTH-1:0]  r_alu_op2;
  logic [OPSEL_W-1:0] r_alu_opsel;
  logic               r_alu_mode;
  logic [DWIDTH-1:0]  r_out_result;
  alu_flags_t         r_out_flags;

  logic w_in_ready;
  logic w_accept;
  logic w_capture;

  // NOTE: every always_comb output gets a default before the case so that no
  // path leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        // Retire and accept on the same edge so streaming has no bubble.
        if (out_ready) begin
          w_in_ready   = 1'b1;
          w_next_state = in_valid ? ST_SETTLE : ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_accept = in_valid & w_in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: these are plain registers, not a memory array, so they take the async
  // reset; that guarantees all-zero outputs the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_alu_op1   <= '0;
      r_alu_op2   <= '0;
      r_alu_opsel <= '0;
      r_alu_mode  <= 1'b0;
    end else if (w_accept) begin
      r_cnt       <= CNT_LOAD;
      r_alu_op1   <= in_op1;
      r_alu_op2   <= in_op2;
      r_alu_opsel <= in_opsel;
      r_alu_mode  <= in_mode;
    end else if (r_state == ST_SETTLE && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Result registers keep their last capture after the handshake completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_result <= '0;
      r_out_flags  <= '0;
    end else if (w_capture) begin
      r_out_result <= alu_result;
      r_out_flags  <= '{c: alu_c, z: alu_z, o: alu_o, s: alu_s};
    end
  end

  assign in_ready   = w_in_ready;
  assign alu_op1    = r_alu_op1;
  assign alu_op2    = r_alu_op2;
  assign alu_opsel  = r_alu_opsel;
  assign alu_mode   = r_alu_mode;
  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl: three instances (settle 2, 1, 15), each
// with a behavioural ALU beside it, checked against a transaction-level model.
module tb_alu_seq_ctrl;

  localparam int DW = 128;
  localparam int NL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NL-1:0] rst, in_valid, in_ready, in_mode, alu_mode;
  logic [NL-1:0] out_valid, out_ready, busy, ovr_en;
  logic [DW-1:0] in_op1 [NL];
  logic [DW-1:0] in_op2 [NL];
  logic [2:0]    in_opsel [NL];
  logic [DW-1:0] alu_op1 [NL];
  logic [DW-1:0] alu_op2 [NL];
  logic [2:0]    alu_opsel [NL];
  logic [DW-1:0] out_result [NL];
  logic [3:0]    out_flags [NL];
  logic [DW-1:0] ovr_res [NL];
  logic [3:0]    ovr_fl [NL];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int settle_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  // Reference ALU: returns {c,z,o,s,result}. Arithmetic mode: opsel[0] picks
  // add/sub. Logic mode: opsel[1:0] picks and/or/xor/not-op1.
  function automatic logic [DW+3:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [2:0] sel, input logic mode);
    logic [DW:0]   w;
    logic [DW-1:0] r;
    logic c, o;
    c = 1'b0;
    o = 1'b0;
    if (mode) begin
      if (!sel[0]) begin
        w = {1'b0, a} + {1'b0, b};
        o = (a[DW-1] == b[DW-1]) && (w[DW-1] != a[DW-1]);
      end else begin
        w = {1'b0, a} - {1'b0, b};
        o = (a[DW-1] != b[DW-1]) && (w[DW-1] != a[DW-1]);
      end
      c = w[DW];
      r = w[DW-1:0];
    end else begin
      case (sel[1:0])
        2'd0:    r = a & b;
        2'd1:    r = a | b;
        2'd2:    r = a ^ b;
        default: r = ~a;
      endcase
    end
    return {c, (r == '0), o, r[DW-1], r};
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    logic [DW+3:0] w_ref;
    logic [DW-1:0] w_res;
    logic [3:0]    w_fl;
    always_comb w_ref = alu_ref(alu_op1[g], alu_op2[g], alu_opsel[g], alu_mode[g]);
    assign w_res = ovr_en[g] ? ovr_res[g] : w_ref[DW-1:0];
    assign w_fl  = ovr_en[g] ? ovr_fl[g]  : w_ref[DW+3:DW];

    alu_seq_ctrl #(
      .DWIDTH       (DW),
      .SETTLE_CYCLES((g == 0) ? 2 : ((g == 1) ? 1 : 15))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_op1    (in_op1[g]),
      .in_op2    (in_op2[g]),
      .in_opsel  (in_opsel[g]),
      .in_mode   (in_mode[g]),
      .alu_op1   (alu_op1[g]),
      .alu_op2   (alu_op2[g]),
      .alu_opsel (alu_opsel[g]),
      .alu_mode  (alu_mode[g]),
      .alu_result(w_res),
      .alu_c     (w_fl[3]),
      .alu_z     (w_fl[2]),
      .alu_o     (w_fl[1]),
      .alu_s     (w_fl[0]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_result(out_result[g]),
      .out_flags (out_flags[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {(DW-1){1'b1}}};
      3:       v = DW'(1) << $urandom_range(0, DW-1);
      default: v = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic rnd_request(input int k);
    in_op1[k]   = rnd_word();
    in_op2[k]   = rnd_word();
    in_opsel[k] = 3'($urandom_range(0, 7));
    in_mode[k]  = 1'($urandom_range(0, 1));
  endtask

  // Presents a request at a falling edge and returns just after the accept edge.
  task automatic send(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [2:0] sel, input logic m);
    bit ok;
    @(negedge clk);
    in_op1[k] = a; in_op2[k] = b; in_opsel[k] = sel; in_mode[k] = m;
    in_valid[k] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (in_ready[k]) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) check("send_timeout", DW'(0), DW'(1));
  endtask

  // Counts edges from accept until out_valid; with noise, keeps hammering in_valid.
  task automatic wait_result(input int k, input logic [DW-1:0] exp_res,
                             input logic [3:0] exp_fl, input bit noise);
    logic [DW-1:0] a0;
    int  lat;
    bit  done;
    #1;
    a0   = alu_op1[k];
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      in_valid[k] = noise;
      if (noise) in_op1[k] = ~a0;
      @(posedge clk);
      #1;
      lat++;
      if (noise) begin
        check("settle_op1_hold", alu_op1[k], a0);
        check("settle_in_ready", DW'(in_ready[k]), DW'(0));
      end
      done = out_valid[k];
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
    check("latency", DW'(lat), DW'(settle_of(k)));
    check("result", out_result[k], exp_res);
    check("flags", DW'(out_flags[k]), DW'(exp_fl));
    check("busy_done", DW'(busy[k]), DW'(1));
  endtask

  task automatic retire(input int k, input int hold);
    logic [DW-1:0] r;
    logic [3:0]    f;
    r = out_result[k];
    f = out_flags[k];
    repeat (hold) @(negedge clk);
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    check("retire_valid", DW'(out_valid[k]), DW'(0));
    check("retire_busy", DW'(busy[k]), DW'(0));
    check("retire_keep_res", out_result[k], r);
    check("retire_keep_flg", DW'(out_flags[k]), DW'(f));
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  task automatic backpressure(input int k, input int cycles);
    logic [DW-1:0] r, a;
    logic [3:0]    f;
    r = out_result[k];
    f = out_flags[k];
    a = alu_op1[k];
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      ovr_en[k]   = 1'b1;
      ovr_res[k]  = {$urandom, $urandom, $urandom, $urandom};
      ovr_fl[k]   = 4'($urandom_range(0, 15));
      in_valid[k] = 1'b1;
      in_op1[k]   = ~a;
      @(posedge clk);
      #1;
      check("bp_result", out_result[k], r);
      check("bp_flags", DW'(out_flags[k]), DW'(f));
      check("bp_in_ready", DW'(in_ready[k]), DW'(0));
      check("bp_op1", alu_op1[k], a);
      check("bp_valid", DW'(out_valid[k]), DW'(1));
    end
    @(negedge clk);
    ovr_en[k]   = 1'b0;
    in_valid[k] = 1'b0;
  endtask

  // Free-running stream with both handshakes held high; results must come out
  // in order, one every settle+1 cycles.
  task automatic stream(input int k, input int ncyc);
    logic [DW+3:0] q[$];
    logic [DW+3:0] e;
    int last, nres;
    bit pend;
    last = -1;
    nres = 0;
    pend = 1'b0;
    @(negedge clk);
    out_ready[k] = 1'b1;
    in_valid[k]  = 1'b1;
    rnd_request(k);
    for (int c = 0; c < ncyc; c++) begin
      #1;
      if (out_valid[k]) begin
        if (q.size() == 0) begin
          check("stream_spurious", DW'(1), DW'(0));
        end else begin
          e = q.pop_front();
          check("stream_result", out_result[k], e[DW-1:0]);
          check("stream_flags", DW'(out_flags[k]), DW'(e[DW+3:DW]));
        end
        if (last >= 0) check("stream_interval", DW'(c - last), DW'(settle_of(k) + 1));
        last = c;
        nres++;
      end
      if (pend) begin
        rnd_request(k);
        pend = 1'b0;
      end
      if (in_ready[k]) begin
        q.push_back(alu_ref(in_op1[k], in_op2[k], in_opsel[k], in_mode[k]));
        pend = 1'b1;
      end
      @(negedge clk);
    end
    in_valid[k] = 1'b0;
    repeat (settle_of(k) + 3) @(negedge clk);
    out_ready[k] = 1'b0;
    check("stream_count", DW'(nres >= ncyc / (settle_of(k) + 1) - 1), DW'(1));
  endtask

  task automatic check_zero(input int k, input string tag);
    check({tag, "_valid"}, DW'(out_valid[k]), DW'(0));
    check({tag, "_busy"}, DW'(busy[k]), DW'(0));
    check({tag, "_op1"}, alu_op1[k], '0);
    check({tag, "_op2"}, alu_op2[k], '0);
    check({tag, "_opsel"}, DW'(alu_opsel[k]), DW'(0));
    check({tag, "_mode"}, DW'(alu_mode[k]), DW'(0));
    check({tag, "_result"}, out_result[k], '0);
    check({tag, "_flags"}, DW'(out_flags[k]), DW'(0));
  endtask

  initial begin
    logic [DW+3:0] e;
    bit seen;
    rst = '1; in_valid = '0; out_ready = '0; ovr_en = '0; in_mode = '0;
    for (int k = 0; k < NL; k++) begin
      in_op1[k] = '0; in_op2[k] = '0; in_opsel[k] = '0;
      ovr_res[k] = '0; ovr_fl[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst = '0;
    #1;
    for (int k = 0; k < NL; k++) begin
      check_zero(k, "reset");
      check("reset_in_ready", DW'(in_ready[k]), DW'(1));
    end

    // Single add 5+3 on the settle-2 lane.
    send(0, DW'(5), DW'(3), 3'd0, 1'b1);
    wait_result(0, DW'(8), 4'b0000, 1'b0);

    // Hold the result under backpressure while the ALU output wanders.
    backpressure(0, 10);

    // Retire and accept on the same edge: all-ones + 1 wraps to zero with carry.
    in_op1[0] = '1; in_op2[0] = DW'(1); in_opsel[0] = 3'd0; in_mode[0] = 1'b1;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_valid_drop", DW'(out_valid[0]), DW'(0));
    check("b2b_op1", alu_op1[0], '1);
    check("b2b_busy", DW'(busy[0]), DW'(1));
    out_ready[0] = 1'b0;
    wait_result(0, '0, 4'b1100, 1'b0);
    retire(0, 0);

    for (int i = 0; i < 25; i++) begin
      logic [DW-1:0] a, b;
      logic [2:0] sel;
      logic m;
      a = rnd_word(); b = rnd_word();
      sel = 3'($urandom_range(0, 7)); m = 1'($urandom_range(0, 1));
      e = alu_ref(a, b, sel, m);
      send(0, a, b, sel, m);
      wait_result(0, e[DW-1:0], e[DW+3:DW], (i % 3) == 0);
      retire(0, $urandom_range(0, 3));
    end

    // Reset one cycle after accept discards the operation.
    send(0, DW'(7), DW'(9), 3'd0, 1'b1);
    @(posedge clk);
    #2;
    rst[0] = 1'b1;
    in_valid[0] = 1'b0;
    #1;
    check_zero(0, "rst_settle");
    @(negedge clk);
    rst[0] = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen |= out_valid[0];
    end
    check("rst_no_valid", DW'(seen), DW'(0));
    check("rst_in_ready", DW'(in_ready[0]), DW'(1));

    stream(0, 60);

    // Settle-1 lane.
    e = alu_ref(DW'(100), DW'(101), 3'd1, 1'b1);
    send(1, DW'(100), DW'(101), 3'd1, 1'b1);
    wait_result(1, e[DW-1:0], e[DW+3:DW], 1'b1);
    retire(1, 1);
    stream(1, 40);

    // Settle-15 lane, with in_valid held high throughout SETTLE.
    e = alu_ref({1'b0, {(DW-1){1'b1}}}, DW'(1), 3'd0, 1'b1);
    send(2, {1'b0, {(DW-1){1'b1}}}, DW'(1), 3'd0, 1'b1);
    wait_result(2, e[DW-1:0], e[DW+3:DW], 1'b1);
    retire(2, 2);
    stream(2, 96);

    // Reset while a result waits in DONE.
    e = alu_ref(DW'(12), DW'(10), 3'd2, 1'b0);
    send(2, DW'(12), DW'(10), 3'd2, 1'b0);
    wait_result(2, e[DW-1:0], e[DW+3:DW], 1'b0);
    #1;
    rst[2] = 1'b1;
    #1;
    check_zero(2, "rst_done");
    #1;
    rst[2] = 1'b0;
    @(negedge clk);
    check("rst_done_in_ready", DW'(in_ready[2]), DW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
